mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared memory/IO bus of the multi-cycle MIPS system.
- Requester 0 is the CPU memory stage. Requester 1 is the loader/debug port.
- Downstream, the block drives the single memory decoder port: write enable, address, write data, read data. Address bit 7 selects IO; the arbiter treats both regions identically.
- Round-robin grant. Fixed, parameterised read latency. One-cycle acknowledge per transaction.

Parameters:
- ADDR_W, 32, address width of requester and bus ports.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles the bus address is held before bus_rdata is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req  input  1  requester 0 transaction request, level.
- m0_we  input  1  requester 0 write (1) / read (0).
- m0_addr  input  ADDR_W  requester 0 byte address.
- m0_wdata  input  DATA_W  requester 0 write data.
- m0_ack  output  1  one-cycle completion pulse to requester 0.
- m0_rdata  output  DATA_W  read result for requester 0; valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: identical to the m0_* ports, for requester 1.
- bus_we  output  1  write enable to the memory decoder.
- bus_addr  output  ADDR_W  address to the memory decoder.
- bus_wdata  output  DATA_W  write data to the memory decoder.
- bus_rdata  input  DATA_W  read data from the memory decoder.
- busy  output  1  high in any state except IDLE.
- owner  output  1  index of the current or last granted requester.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Round-robin pointer rr=0, so m0 has priority first.
  - Latency counter cleared; latched request cleared.
  - A transaction in flight is abandoned: no ack is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, select a winner:
    - only one req high: that requester wins;
    - both high: rr selects the winner.
  - Latch the winner's we/addr/wdata into the internal request register, set owner to the winner, set rr to the other index, load cnt, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - bus_addr and bus_wdata are driven from the latched register, which is stable for the whole state.
  - Write: bus_we=1 for exactly this one cycle, then go to DONE.
  - Read: bus_we=0. Stay in ACCESS for RD_LAT cycles (cnt counts down from RD_LAT-1). On the last cycle, register bus_rdata into the owner's rdata, then go to DONE.
- DONE:
  - The owner's ack is 1 for exactly one cycle; the other ack stays 0. Then go to IDLE.
- Latency, from the req-sampling edge to the ack-high cycle:
  - write: 2 cycles;
  - read: RD_LAT+1 cycles.
  - IDLE costs one cycle between back-to-back transactions.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack is seen.
  - Drop req in the cycle after ack. A req still high in the IDLE cycle after DONE is treated as a new transaction.
- Requests arriving while busy are ignored until IDLE, with no loss. The waiting requester simply holds req.
- Starvation-free: with both requesters continuously requesting, grants strictly alternate.
- bus_addr and bus_wdata keep their last values in IDLE and DONE. bus_we is 0 outside write ACCESS cycles.
- mN_rdata holds its last captured value until the next read completes for that requester. Writes do not alter it.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Single read: m0_req with addr=0x00000010, bus_rdata=0xDEADBEEF, RD_LAT=1 → bus_addr=0x10 one cycle after req is sampled. m0_ack pulses on the following cycle with m0_rdata=0xDEADBEEF. m1_ack stays 0.
- Single write: m1 write to addr=0x00000084 (IO region), wdata=0x000000A5 → bus_we=1 for exactly one cycle with bus_addr=0x84 and bus_wdata=0xA5. m1_ack pulses next cycle; owner=1.
- Simultaneous requests out of reset: both reads, m0 addr=0x4, m1 addr=0x8 → m0 served first, then m1 after one IDLE cycle. Repeat with both held continuously: grants alternate 0,1,0,1 and each ack appears exactly once per transaction.
- RD_LAT=3: m0 read of 0x20 → bus_addr=0x20 held for 3 cycles. bus_rdata is sampled only on the 3rd cycle; change it to 0x1111 in cycle 1 and 0x2222 in cycle 3 → m0_rdata=0x2222.
- Reset mid-read: assert reset=0 during ACCESS → state and outputs go to 0 immediately, with no ack. After release, a simultaneous request is granted to m0 (rr=0).
- Late request: m1 raises req while an m0 write is in ACCESS → m1 is granted in the IDLE cycle after m0's DONE. m0's latched address is unaffected by m1_addr toggling.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and memory-decoder signals of the shared MIPS bus.
// Ports of the slave (arbiter) view:
//   m0_*/m1_* : req, we, addr, wdata in; ack, rdata out
//   bus_*     : we, addr, wdata out; rdata in
//   busy, owner : status out
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req, m0_we, m0_ack;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_ack;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;
    logic              busy, owner;
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata, bus_we, bus_addr, bus_wdata, busy, owner
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata, bus_we, bus_addr, bus_wdata, busy, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-requester arbiter/sequencer for the shared memory/IO bus.
// Ports: clk, reset (async, active-low), b (mem_bus_arbiter_if.slave: requesters, bus, busy, owner).
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic reset,
    mem_bus_arbiter_if.slave b
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t     state;
    logic       rr;
    logic       lat_we;
    logic [3:0] cnt;
    logic       pick;
    // Single requester wins outright; rr only breaks ties.
    always_comb pick = (b.m0_req && b.m1_req) ? rr : b.m1_req;
    // bus_addr/bus_wdata double as the latched request register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr          <= 1'b0;
            lat_we      <= 1'b0;
            cnt         <= 4'd0;
            b.bus_we    <= 1'b0;
            b.bus_addr  <= {ADDR_W{1'b0}};
            b.bus_wdata <= {DATA_W{1'b0}};
            b.m0_rdata  <= {DATA_W{1'b0}};
            b.m1_rdata  <= {DATA_W{1'b0}};
            b.m0_ack    <= 1'b0;
            b.m1_ack    <= 1'b0;
            b.busy      <= 1'b0;
            b.owner     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (b.m0_req || b.m1_req) begin
                    state       <= ACCESS;
                    b.owner     <= pick;
                    rr          <= ~pick;
                    lat_we      <= pick ? b.m1_we : b.m0_we;
                    b.bus_we    <= pick ? b.m1_we : b.m0_we;
                    b.bus_addr  <= pick ? b.m1_addr : b.m0_addr;
                    b.bus_wdata <= pick ? b.m1_wdata : b.m0_wdata;
                    cnt         <= 4'(RD_LAT - 1);
                    b.busy      <= 1'b1;
                end
                ACCESS: if (lat_we || cnt == 4'd0) begin
                    state    <= DONE;
                    b.bus_we <= 1'b0;
                    if (!lat_we && !b.owner) b.m0_rdata <= b.bus_rdata;
                    if (!lat_we && b.owner) b.m1_rdata <= b.bus_rdata;
                    b.m0_ack <= !b.owner;
                    b.m1_ack <= b.owner;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    state    <= IDLE;
                    b.m0_ack <= 1'b0;
                    b.m1_ack <= 1'b0;
                    b.busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
